shift_panel_ctrl: RTL



---
 rtl/shift_panel_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/shift_panel_ctrl.sv
// Switch/LED panel input controller: synchronizes and debounces three buttons and
// turns each press into one load or rotate-through-carry command on the LED register.
module shift_panel_ctrl #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] SW,
    input  logic             btn_load,
    input  logic             ssl,
    input  logic             ssr,
    output logic [WIDTH-1:0] LED,
    output logic             carry,
    output logic [CNT_W-1:0] step_count,
    output logic             cmd_valid
);

    localparam int unsigned NBTN     = 3;
    localparam int unsigned BTN_LOAD = 0;
    localparam int unsigned BTN_SSL  = 1;
    localparam int unsigned BTN_SSR  = 2;
    localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] db_vec;
    logic [NBTN-1:0] db_prev_q;
    logic [NBTN-1:0] press_q;

    assign btn_raw = {ssr, ssl, btn_load};

    for (genvar b = 0; b < NBTN; b++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DB_W-1:0]        cnt_q;
        logic [DB_W-1:0]        cnt_d;
        logic                   db_q;
        logic                   db_d;
        logic                   raw;

        assign raw = sync_q[SYNC_STAGES-1];

        // Level must differ from the accepted one for DEBOUNCE_CYCLES straight cycles.
        always_comb begin
            cnt_d = cnt_q;
            db_d  = db_q;
            if (raw == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d  = raw;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sync_q <= '0;
                cnt_q  <= '0;
                db_q   <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[b]};
                cnt_q  <= cnt_d;
                db_q   <= db_d;
            end
        end

        assign db_vec[b] = db_q;
    end

    // Registered rising-edge detect: one press pulse per accepted 0->1 level change.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_prev_q <= '0;
            press_q   <= '0;
        end else begin
            db_prev_q <= db_vec;
            press_q   <= db_vec & ~db_prev_q;
        end
    end

    logic [WIDTH-1:0] led_q,   led_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] step_q,  step_d;
    logic             valid_q, valid_d;

    // Load has priority; opposing rotates in the same cycle cancel.
    always_comb begin
        led_d   = led_q;
        carry_d = carry_q;
        step_d  = step_q;
        valid_d = 1'b0;
        if (press_q[BTN_LOAD]) begin
            led_d   = SW;
            carry_d = 1'b0;
            valid_d = 1'b1;
        end else if (press_q[BTN_SSL] && !press_q[BTN_SSR]) begin
            led_d   = {led_q[WIDTH-2:0], carry_q};
            carry_d = led_q[WIDTH-1];
            step_d  = step_q + CNT_W'(1);
            valid_d = 1'b1;
        end else if (press_q[BTN_SSR] && !press_q[BTN_SSL]) begin
            led_d   = {carry_q, led_q[WIDTH-1:1]};
            carry_d = led_q[0];
            step_d  = step_q + CNT_W'(1);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_q   <= '0;
            carry_q <= 1'b0;
            step_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            led_q   <= led_d;
            carry_q <= carry_d;
            step_q  <= step_d;
            valid_q <= valid_d;
        end
    end

    assign LED        = led_q;
    assign carry      = carry_q;
    assign step_count = step_q;
    assign cmd_valid  = valid_q;

endmodule
